// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_access_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] dataBus_u;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } memOpType_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } maState_e;

    function automatic logic is_load(input memOpType_e op);
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input memOpType_e op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input memOpType_e op, input logic [1:0] off);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return off[0];
            MEM_LW, MEM_SW:          return |off;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_lsu_align.sv
// Combinational byte-lane logic: store enables/replication, load shift and extension.
module lsu_align
    import mem_access_pkg::*;
(
    input  memOpType_e  i_mem_op,
    input  logic [1:0]  i_offset,
    input  dataBus_u    i_store_data,
    input  dataBus_u    i_rdata,
    output logic [3:0]  o_be,
    output dataBus_u    o_wdata,
    output dataBus_u    o_load_data,
    output logic        o_misaligned
);

    dataBus_u w_shifted;

    function automatic dataBus_u sext8(input logic signed [7:0] b);
        logic signed [XLEN-1:0] w;
        w = 32'(b);
        return dataBus_u'(w);
    endfunction

    function automatic dataBus_u sext16(input logic signed [15:0] h);
        logic signed [XLEN-1:0] w;
        w = 32'(h);
        return dataBus_u'(w);
    endfunction

    // Lane mask, store replication and load extraction chosen by the op.
    always_comb begin
        w_shifted    = i_rdata >> {i_offset, 3'b000};
        o_be         = 4'b0000;
        o_wdata      = '0;
        o_load_data  = '0;
        o_misaligned = is_misaligned(i_mem_op, i_offset);
        case (i_mem_op)
            MEM_LB: begin
                o_be        = 4'b0001 << i_offset;
                o_load_data = sext8(w_shifted[7:0]);
            end
            MEM_LBU: begin
                o_be        = 4'b0001 << i_offset;
                o_load_data = {24'd0, w_shifted[7:0]};
            end
            MEM_LH: begin
                o_be        = 4'b0011 << i_offset;
                o_load_data = sext16(w_shifted[15:0]);
            end
            MEM_LHU: begin
                o_be        = 4'b0011 << i_offset;
                o_load_data = {16'd0, w_shifted[15:0]};
            end
            MEM_LW: begin
                o_be        = 4'hF;
                o_load_data = w_shifted;
            end
            MEM_SB: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_store_data[7:0]}};
            end
            MEM_SH: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_store_data[15:0]}};
            end
            MEM_SW: begin
                o_be    = 4'hF;
                o_wdata = i_store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: MA/WB registers, data-memory handshake FSM, response buffer.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_ex_valid,
    input  dataBus_u    i_alu_result,
    input  dataBus_u    i_rs2_data,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_reg_write,
    input  memOpType_e  i_mem_op,
    output dataBus_u    o_alu_ma,
    output logic [4:0]  o_rd_ma,
    output logic        o_reg_write_ma,
    output logic        o_stall_ma,
    output logic        o_misalign_exc,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output dataBus_u    o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output dataBus_u    o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  dataBus_u    i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output dataBus_u    o_wb_data
);

    maState_e   r_state;
    maState_e   w_state_nxt;
    logic       w_ready;
    logic       w_advance;

    // MA register (stage 1)
    logic       r_vld_p1;
    dataBus_u   r_alu_p1;
    dataBus_u   r_rs2_p1;
    logic [4:0] r_rd_p1;
    logic       r_we_p1;
    memOpType_e r_op_p1;
    logic       r_mis_p1;

    // WB register (stage 2)
    logic       r_vld_p2;
    logic [4:0] r_rd_p2;
    dataBus_u   r_data_p2;

    dataBus_u   r_rsp_buf;

    memOpType_e w_ex_op;
    logic       w_ex_mis;
    logic       w_ex_access;
    logic       w_ma_store;
    logic       w_rsp_hit;
    dataBus_u   w_load_src;
    logic [3:0] w_be;
    dataBus_u   w_wdata;
    dataBus_u   w_load_data;
    logic       w_ma_mis;

    // A bubble enters MA as a no-op so it can never start an access.
    assign w_ex_op     = i_ex_valid ? i_mem_op : MEM_NONE;
    assign w_ex_mis    = is_misaligned(w_ex_op, i_alu_result[1:0]);
    assign w_ex_access = (is_load(w_ex_op) | is_store(w_ex_op)) & ~w_ex_mis;
    assign w_ma_store  = is_store(r_op_p1);

    // Read data is used directly on the rvalid cycle, otherwise from the buffer.
    assign w_rsp_hit  = (r_state == RSP) & i_dmem_rvalid;
    assign w_load_src = w_rsp_hit ? i_dmem_rdata : r_rsp_buf;

    lsu_align u_lsu_align (
        .i_mem_op     (r_op_p1),
        .i_offset     (r_alu_p1[1:0]),
        .i_store_data (r_rs2_p1),
        .i_rdata      (w_load_src),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_ma_mis)
    );

    // Handshake next-state and the ready term that gates pipeline advance.
    always_comb begin
        w_ready     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_ready = 1'b1;
            REQ: begin
                w_ready = w_ma_store & i_dmem_gnt;
                if (i_dmem_gnt) begin
                    w_state_nxt = w_ma_store ? DONE : RSP;
                end
            end
            RSP: begin
                w_ready = i_dmem_rvalid;
                if (i_dmem_rvalid) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: w_ready = 1'b1;
            default: w_state_nxt = IDLE;
        endcase
        if (i_clk_en & w_ready) begin
            w_state_nxt = w_ex_access ? REQ : IDLE;
        end
    end

    assign w_advance = i_clk_en & w_ready;

    // FSM state register; runs regardless of clk_en so the handshake is never lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response buffer captures read data whenever it arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_buf <= '0;
        end else if (w_rsp_hit) begin
            r_rsp_buf <= i_dmem_rdata;
        end
    end

    // EX -> MA boundary
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_p1 <= 1'b0;
            r_alu_p1 <= '0;
            r_rs2_p1 <= '0;
            r_rd_p1  <= '0;
            r_we_p1  <= 1'b0;
            r_op_p1  <= MEM_NONE;
            r_mis_p1 <= 1'b0;
        end else if (w_advance) begin
            r_vld_p1 <= i_ex_valid;
            r_alu_p1 <= i_alu_result;
            r_rs2_p1 <= i_rs2_data;
            r_rd_p1  <= i_rd_addr;
            r_we_p1  <= i_reg_write & i_ex_valid;
            r_op_p1  <= w_ex_op;
            r_mis_p1 <= w_ex_mis;
        end
    end

    // MA -> WB boundary
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_p2  <= 1'b0;
            r_rd_p2   <= '0;
            r_data_p2 <= '0;
        end else if (w_advance) begin
            r_vld_p2  <= r_vld_p1 & r_we_p1 & ~w_ma_mis;
            r_rd_p2   <= r_rd_p1;
            r_data_p2 <= is_load(r_op_p1) ? w_load_data : r_alu_p1;
        end
    end

    assign o_alu_ma       = r_alu_p1;
    assign o_rd_ma        = r_rd_p1;
    assign o_reg_write_ma = r_we_p1;
    assign o_stall_ma     = ~w_ready;
    assign o_misalign_exc = r_mis_p1;

    assign o_dmem_req   = (r_state == REQ);
    assign o_dmem_we    = w_ma_store;
    assign o_dmem_addr  = {r_alu_p1[31:2], 2'b00};
    assign o_dmem_be    = w_be;
    assign o_dmem_wdata = w_wdata;

    assign o_wb_valid = r_vld_p2;
    assign o_wb_rd    = r_rd_p2;
    assign o_wb_data  = r_data_p2;

endmodule
